game_step_sequencer: RTL and testbench

//  Sequences one snake-game update per qualified game tick: latch direction, request a snake

---
 rtl/game_step_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_game_step_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_step_sequencer.sv
// rtl/game_step_sequencer.sv - per-tick snake game step sequencer
// Owns score, speed level, pause, game-over and move/draw handshakes with ack timeout.
module game_step_sequencer #(
    parameter int SCORE_W         = 8,
    parameter int MAX_LEVEL       = 3,
    parameter int FOODS_PER_LEVEL = 4,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tick_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic [1:0]         dir_in_i,
    output logic               move_req_o,
    input  logic               move_ack_i,
    input  logic               collide_i,
    input  logic               ate_food_i,
    output logic               draw_req_o,
    input  logic               draw_ack_i,
    output logic [1:0]         dir_out_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [1:0]         level_o,
    output logic               game_over_o,
    output logic               fault_o,
    output logic [7:0]         overrun_cnt_o
);

    localparam int FOOD_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
    localparam int TMO_W  = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [1:0]         MAX_LVL   = 2'(MAX_LEVEL);
    localparam logic [FOOD_W-1:0]  FOOD_LAST = FOOD_W'(FOODS_PER_LEVEL - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_MOVE,
        S_DRAW,
        S_PAUSED,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic               move_req_q, move_req_d;
    logic               draw_req_q, draw_req_d;
    logic [1:0]         dir_q, dir_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         level_q, level_d;
    logic               game_over_q, game_over_d;
    logic               fault_q, fault_d;
    logic [7:0]         overrun_q, overrun_d;
    logic [1:0]         skip_cnt_q, skip_cnt_d;
    logic [FOOD_W-1:0]  food_cnt_q, food_cnt_d;
    logic [TMO_W-1:0]   timeout_q, timeout_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            move_req_q  <= 1'b0;
            draw_req_q  <= 1'b0;
            dir_q       <= 2'b01;
            score_q     <= '0;
            level_q     <= '0;
            game_over_q <= 1'b0;
            fault_q     <= 1'b0;
            overrun_q   <= '0;
            skip_cnt_q  <= '0;
            food_cnt_q  <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            move_req_q  <= move_req_d;
            draw_req_q  <= draw_req_d;
            dir_q       <= dir_d;
            score_q     <= score_d;
            level_q     <= level_d;
            game_over_q <= game_over_d;
            fault_q     <= fault_d;
            overrun_q   <= overrun_d;
            skip_cnt_q  <= skip_cnt_d;
            food_cnt_q  <= food_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        move_req_d  = move_req_q;
        draw_req_d  = draw_req_q;
        dir_d       = dir_q;
        score_d     = score_q;
        level_d     = level_q;
        game_over_d = game_over_q;
        fault_d     = fault_q;
        overrun_d   = overrun_q;
        skip_cnt_d  = skip_cnt_q;
        food_cnt_d  = food_cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    score_d     = '0;
                    level_d     = '0;
                    food_cnt_d  = '0;
                    skip_cnt_d  = '0;
                    overrun_d   = '0;
                    fault_d     = 1'b0;
                    game_over_d = 1'b0;
                    dir_d       = 2'b01;
                    state_d     = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (pause_i) begin
                    state_d = S_PAUSED;
                end else if (tick_i) begin
                    // Tick decimation: higher levels skip fewer ticks.
                    if (skip_cnt_q == MAX_LVL - level_q) begin
                        skip_cnt_d = '0;
                        if (dir_in_i != (dir_q ^ 2'b10)) dir_d = dir_in_i;
                        move_req_d = 1'b1;
                        timeout_d  = '0;
                        state_d    = S_MOVE;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 2'd1;
                    end
                end
            end
            S_MOVE: begin
                if (move_ack_i) begin
                    move_req_d = 1'b0;
                    if (collide_i) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else begin
                        if (ate_food_i) begin
                            if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                            if (food_cnt_q == FOOD_LAST) begin
                                food_cnt_d = '0;
                                if (level_q != MAX_LVL) level_d = level_q + 2'd1;
                            end else begin
                                food_cnt_d = food_cnt_q + FOOD_W'(1);
                            end
                        end
                        draw_req_d = 1'b1;
                        timeout_d  = '0;
                        state_d    = S_DRAW;
                    end
                end else if (timeout_q == TMO_LAST) begin
                    move_req_d  = 1'b0;
                    fault_d     = 1'b1;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    timeout_d = timeout_q + TMO_W'(1);
                end
            end
            S_DRAW: begin
                if (draw_ack_i) begin
                    draw_req_d = 1'b0;
                    state_d    = S_WAIT_TICK;
                end else if (timeout_q == TMO_LAST) begin
                    draw_req_d  = 1'b0;
                    fault_d     = 1'b1;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    timeout_d = timeout_q + TMO_W'(1);
                end
            end
            S_PAUSED: begin
                if (!pause_i) state_d = S_WAIT_TICK;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_MOVE || state_q == S_DRAW) && tick_i && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;
    end

    assign move_req_o    = move_req_q;
    assign draw_req_o    = draw_req_q;
    assign dir_out_o     = dir_q;
    assign score_o       = score_q;
    assign level_o       = level_q;
    assign game_over_o   = game_over_q;
    assign fault_o       = fault_q;
    assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_game_step_sequencer.sv
// tb/tb_game_step_sequencer.sv - directed self-checking bench for game_step_sequencer
// A small game model predicts move firing, direction, score and level; results queued per move.
module tb_game_step_sequencer;

    logic       clk = 1'b0;
    logic       resetn, tick, start, pause, move_ack, collide, ate_food, draw_ack;
    logic [1:0] dir_in;
    logic       move_req, draw_req, game_over, fault;
    logic [1:0] dir_out, level;
    logic [7:0] score, overrun_cnt;

    always #5 clk = ~clk;

    game_step_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .tick_i       (tick),
        .start_i      (start),
        .pause_i      (pause),
        .dir_in_i     (dir_in),
        .move_req_o   (move_req),
        .move_ack_i   (move_ack),
        .collide_i    (collide),
        .ate_food_i   (ate_food),
        .draw_req_o   (draw_req),
        .draw_ack_i   (draw_ack),
        .dir_out_o    (dir_out),
        .score_o      (score),
        .level_o      (level),
        .game_over_o  (game_over),
        .fault_o      (fault),
        .overrun_cnt_o(overrun_cnt)
    );

    typedef struct packed {
        logic [1:0] dir;
        logic [7:0] score;
        logic [1:0] level;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   mv_rises = 0;
    int   dr_rises = 0;
    logic prev_mv = 1'b0;
    logic prev_dr = 1'b0;

    logic [1:0] m_dir;
    int         m_score, m_level, m_food, m_skip;

    always @(negedge clk) begin
        if (move_req && !prev_mv) mv_rises++;
        if (draw_req && !prev_dr) dr_rises++;
        prev_mv = move_req;
        prev_dr = draw_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic new_game();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        m_dir = 2'b01; m_score = 0; m_level = 0; m_food = 0; m_skip = 0;
    endtask

    task automatic send_tick(input logic [1:0] d, input logic food, input logic coll,
                             input logic hold_draw, input logic pause_mid);
        exp_t e;
        dir_in = d;
        pulse_tick();
        if (m_skip != 3 - m_level) begin
            m_skip++;
            chk("no_move_req", move_req, 0);
        end else begin
            m_skip = 0;
            if (d != (m_dir ^ 2'b10)) m_dir = d;
            chk("move_req_rise", move_req, 1);
            chk("move_dir_out", dir_out, m_dir);
            if (!coll) begin
                if (food) begin
                    if (m_score != 255) m_score++;
                    if (m_food == 3) begin
                        m_food = 0;
                        if (m_level != 3) m_level++;
                    end else begin
                        m_food++;
                    end
                end
                e = '{m_dir, 8'(m_score), 2'(m_level)};
                sb_q.push_back(e);
            end
            if (pause_mid) pause = 1'b1;
            @(negedge clk) begin move_ack = 1'b1; collide = coll; ate_food = food; end
            @(negedge clk) begin move_ack = 1'b0; collide = 1'b0; ate_food = 1'b0; end
            chk("move_req_drop", move_req, 0);
            if (coll) begin
                chk("collide_game_over", game_over, 1);
                chk("collide_no_draw", draw_req, 0);
            end else if (sb_q.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                e = sb_q.pop_front();
                chk("draw_req_rise", draw_req, 1);
                chk("sb_score", score, e.score);
                chk("sb_level", level, e.level);
                chk("sb_dir", dir_out, e.dir);
                if (!hold_draw) begin
                    @(negedge clk) draw_ack = 1'b1;
                    @(negedge clk) draw_ack = 1'b0;
                    chk("draw_req_drop", draw_req, 0);
                end
            end
        end
    endtask

    initial begin
        int mv0, dr0;
        resetn = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0; dir_in = 2'b01;
        move_ack = 1'b0; collide = 1'b0; ate_food = 1'b0; draw_ack = 1'b0;
        m_dir = 2'b01; m_score = 0; m_level = 0; m_food = 0; m_skip = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_move_req", move_req, 0);
        chk("rst_draw_req", draw_req, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_fault", fault, 0);
        chk("rst_score", score, 0);
        chk("rst_level", level, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_dir", dir_out, 2'b01);
        pulse_tick();
        chk("idle_tick_ignored", move_req, 0);

        // Level 0: one move per four ticks.
        new_game();
        mv0 = mv_rises; dr0 = dr_rises;
        for (int i = 0; i < 4; i++) send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_move_count", mv_rises - mv0, 1);
        chk("t1_draw_count", dr_rises - dr0, 1);

        // Food drives level up; decimation follows the level.
        for (int i = 0; i < 16; i++) send_tick(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_score4", score, 4);
        chk("t2_level1", level, 1);
        for (int i = 0; i < 12; i++) send_tick(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_tick(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_level3", level, 3);
        for (int i = 0; i < 4; i++) send_tick(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_score16", score, 16);
        chk("t2_level_sat", level, 3);

        // Reversal ignored, turn accepted.
        send_tick(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_reverse_ignored", dir_out, 2'b01);
        send_tick(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_turn_up", dir_out, 2'b00);
        send_tick(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_reverse_down", dir_out, 2'b00);

        // Collision with simultaneous food ends the game without scoring.
        send_tick(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_score_frozen", score, 16);
        repeat (3) @(negedge clk);
        chk("t4_still_no_draw", draw_req, 0);
        chk("t4_still_over", game_over, 1);
        pulse_tick();
        chk("t4_over_no_overrun", overrun_cnt, 0);
        new_game();
        chk("t4_restart_score", score, 0);
        chk("t4_restart_level", level, 0);
        chk("t4_restart_dir", dir_out, 2'b01);
        chk("t4_restart_over", game_over, 0);
        for (int i = 0; i < 4; i++) send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

        // Draw ack withheld: timeout on the 1024th cycle in DRAW, ticks counted as overruns.
        for (int i = 0; i < 3; i++) send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        send_tick(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 1024; n++) begin
            @(negedge clk);
            tick = (n == 10 || n == 20 || n == 30);
            if (n == 1023) begin
                chk("t5_no_timeout_yet", game_over, 0);
                chk("t5_draw_held", draw_req, 1);
            end
        end
        tick = 1'b0;
        chk("t5_timeout_over", game_over, 1);
        chk("t5_fault", fault, 1);
        chk("t5_draw_dropped", draw_req, 0);
        chk("t5_overrun3", overrun_cnt, 3);
        chk("t5_score_kept", score, 1);
        new_game();
        chk("t5_fault_cleared", fault, 0);
        chk("t5_overrun_cleared", overrun_cnt, 0);

        // Pause raised mid-move: transaction completes, then ticks are ignored.
        for (int i = 0; i < 3; i++) send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            pulse_tick();
            chk("t6_paused_no_move", move_req, 0);
        end
        chk("t6_paused_no_overrun", overrun_cnt, 0);
        pause = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while move_req is pending.
        for (int i = 0; i < 3; i++) send_tick(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_tick();
        chk("t7_move_pending", move_req, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t7_async_req_drop", move_req, 0);
        chk("t7_async_score", score, 0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        chk("t7_idle_after_reset", move_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
